// File: rtl/ex_stage.sv
// Purpose     : cpu15 execute stage; operand select with write-back forwarding, ALU, iterative shifter.
// Latency     : single-cycle ops write back 1 edge after accept; shifts write back amount+1 edges after accept.
// Backpressure: IN_READY low while a shift is in progress and during RESET; upstream holds its instruction.
//
// Ports:
//   CLK_EX            stage clock, shared with the write-back register file
//   RESET             synchronous active-high reset
//   IN_VALID/IN_READY instruction handshake (accept = both high at a rising edge)
//   OP, N_RD, N_RS    opcode, destination/first operand index, second operand index
//   IMM               8-bit immediate for LDL/LDH
//   REG_0..REG_7      register-file read values
//   N_REG/REG_IN/REG_WEN  write-back index, data, one-cycle enable pulse
//   BUSY              high while the iterative shifter is running
module ex_stage #(
    parameter int DW  = 16,
    parameter int SHW = 4
) (
    input  logic          CLK_EX,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [3:0]    OP,
    input  logic [2:0]    N_RD,
    input  logic [2:0]    N_RS,
    input  logic [7:0]    IMM,
    input  logic [DW-1:0] REG_0,
    input  logic [DW-1:0] REG_1,
    input  logic [DW-1:0] REG_2,
    input  logic [DW-1:0] REG_3,
    input  logic [DW-1:0] REG_4,
    input  logic [DW-1:0] REG_5,
    input  logic [DW-1:0] REG_6,
    input  logic [DW-1:0] REG_7,
    output logic [2:0]    N_REG,
    output logic [DW-1:0] REG_IN,
    output logic          REG_WEN,
    output logic          BUSY
);

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SL  = 4'd5;
    localparam logic [3:0] OP_SR  = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_LDL = 4'd8;
    localparam logic [3:0] OP_LDH = 4'd9;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_acc, w_acc_nxt;
    logic [SHW-1:0]  r_cnt, w_cnt_nxt;
    logic [3:0]      r_op, w_op_nxt;
    logic [2:0]      r_rd, w_rd_nxt;
    logic [DW-1:0]   r_reg_in, w_reg_in_nxt;
    logic [2:0]      r_n_reg, w_n_reg_nxt;
    logic            r_wen, w_wen_nxt;
    logic            r_busy, w_busy_nxt;

    logic [DW-1:0]   w_rf [8];
    logic [DW-1:0]   w_a, w_b;
    logic            w_accept;

    assign w_rf[0] = REG_0;
    assign w_rf[1] = REG_1;
    assign w_rf[2] = REG_2;
    assign w_rf[3] = REG_3;
    assign w_rf[4] = REG_4;
    assign w_rf[5] = REG_5;
    assign w_rf[6] = REG_6;
    assign w_rf[7] = REG_7;

    // The register file only captures REG_IN on the edge where REG_WEN is
    // high, so during that cycle its output for N_REG is still stale.
    assign w_a = (r_wen && (r_n_reg == N_RD)) ? r_reg_in : w_rf[N_RD];
    assign w_b = (r_wen && (r_n_reg == N_RS)) ? r_reg_in : w_rf[N_RS];

    assign IN_READY = (r_state == S_IDLE) && !RESET;
    assign w_accept = IN_VALID && IN_READY;

    assign N_REG   = r_n_reg;
    assign REG_IN  = r_reg_in;
    assign REG_WEN = r_wen;
    assign BUSY    = r_busy;

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_rd_nxt     = r_rd;
        w_reg_in_nxt = r_reg_in;
        w_n_reg_nxt  = r_n_reg;
        w_busy_nxt   = r_busy;
        // Enable is a pulse: every edge that produces no result clears it.
        w_wen_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (OP)
                        OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDL, OP_LDH: begin
                            w_wen_nxt   = 1'b1;
                            w_n_reg_nxt = N_RD;
                            case (OP)
                                OP_MOV:  w_reg_in_nxt = w_b;
                                OP_ADD:  w_reg_in_nxt = w_a + w_b;
                                OP_SUB:  w_reg_in_nxt = w_a - w_b;
                                OP_AND:  w_reg_in_nxt = w_a & w_b;
                                OP_OR:   w_reg_in_nxt = w_a | w_b;
                                OP_LDL:  w_reg_in_nxt = {{(DW-8){1'b0}}, IMM};
                                default: w_reg_in_nxt = {IMM, w_a[7:0]};
                            endcase
                        end
                        OP_SL, OP_SR, OP_SRA: begin
                            w_acc_nxt   = w_a;
                            w_cnt_nxt   = w_b[SHW-1:0];
                            w_op_nxt    = OP;
                            w_rd_nxt    = N_RD;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = S_SHIFT;
                        end
                        default: ; // A..F: consumed as NOP
                    endcase
                end
            end
            S_SHIFT: begin
                if (r_cnt != '0) begin
                    case (r_op)
                        OP_SL:   w_acc_nxt = {r_acc[DW-2:0], 1'b0};
                        OP_SR:   w_acc_nxt = {1'b0, r_acc[DW-1:1]};
                        default: w_acc_nxt = {r_acc[DW-1], r_acc[DW-1:1]};
                    endcase
                    w_cnt_nxt = r_cnt - SHW'(1);
                end else begin
                    w_reg_in_nxt = r_acc;
                    w_n_reg_nxt  = r_rd;
                    w_wen_nxt    = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_EX) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_reg_in <= '0;
            r_n_reg  <= '0;
            r_wen    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op     <= w_op_nxt;
            r_rd     <= w_rd_nxt;
            r_reg_in <= w_reg_in_nxt;
            r_n_reg  <= w_n_reg_nxt;
            r_wen    <= w_wen_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Purpose     : directed self-checking bench for ex_stage.
// Latency     : inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: shift sequences hold IN_VALID high while IN_READY is low.
module tb_ex_stage;

    logic        CLK_EX = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [3:0]  OP;
    logic [2:0]  N_RD, N_RS;
    logic [7:0]  IMM;
    logic [15:0] REG_0, REG_1, REG_2, REG_3, REG_4, REG_5, REG_6, REG_7;
    logic [2:0]  N_REG;
    logic [15:0] REG_IN;
    logic        REG_WEN;
    logic        BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK_EX = ~CLK_EX;

    ex_stage #(.DW(16), .SHW(4)) dut (
        .CLK_EX(CLK_EX), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP(OP), .N_RD(N_RD), .N_RS(N_RS), .IMM(IMM),
        .REG_0(REG_0), .REG_1(REG_1), .REG_2(REG_2), .REG_3(REG_3),
        .REG_4(REG_4), .REG_5(REG_5), .REG_6(REG_6), .REG_7(REG_7),
        .N_REG(N_REG), .REG_IN(REG_IN), .REG_WEN(REG_WEN), .BUSY(BUSY)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_EX);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [7:0] imm);
        OP = op; N_RD = rd; N_RS = rs; IMM = imm; IN_VALID = 1'b1;
    endtask

    task automatic check_wb(input string tag, input logic [2:0] rd, input logic [15:0] val);
        check({tag, ".wen"}, 32'(REG_WEN), 32'd1);
        check({tag, ".nreg"}, 32'(N_REG), 32'(rd));
        check({tag, ".data"}, 32'(REG_IN), 32'(val));
    endtask

    // Shift of REG_[rd] by REG_[rs][3:0]; IN_VALID stays high the whole time.
    task automatic do_shift(input string tag, input logic [3:0] op, input logic [2:0] rd,
                            input logic [2:0] rs, input int amt, input logic [15:0] exp);
        issue(op, rd, rs, 8'h00);
        check({tag, ".rdy0"}, 32'(IN_READY), 32'd1);
        step();
        for (int i = 0; i <= amt; i++) begin
            check({tag, ".busy"}, 32'(BUSY), 32'd1);
            check({tag, ".rdy"}, 32'(IN_READY), 32'd0);
            check({tag, ".wen0"}, 32'(REG_WEN), 32'd0);
            step();
        end
        check_wb(tag, rd, exp);
        check({tag, ".busy_end"}, 32'(BUSY), 32'd0);
        IN_VALID = 1'b0;
        step();
        check({tag, ".once"}, 32'(REG_WEN), 32'd0);
    endtask

    initial begin
        RESET = 1'b1; IN_VALID = 1'b0; OP = '0; N_RD = '0; N_RS = '0; IMM = '0;
        REG_0 = '0; REG_1 = 16'h1111; REG_2 = '0; REG_3 = '0;
        REG_4 = '0; REG_5 = '0; REG_6 = '0; REG_7 = 16'h5555;
        step();
        step();
        check("rst.wen", 32'(REG_WEN), 32'd0);
        check("rst.data", 32'(REG_IN), 32'd0);
        check("rst.nreg", 32'(N_REG), 32'd0);
        check("rst.busy", 32'(BUSY), 32'd0);
        check("rst.rdy", 32'(IN_READY), 32'd0);
        RESET = 1'b0;
        #1;
        check("rst.rdy_rel", 32'(IN_READY), 32'd1);

        // LDL R1, 0xA5
        issue(4'd8, 3'd1, 3'd0, 8'hA5);
        step();
        check_wb("ldl", 3'd1, 16'h00A5);
        IN_VALID = 1'b0;
        step();
        check("ldl.pulse", 32'(REG_WEN), 32'd0);

        // back-to-back ADD / SUB with forwarding of R2
        REG_2 = 16'hFFFF; REG_3 = 16'h0002;
        issue(4'd1, 3'd2, 3'd3, 8'h00);
        step();
        check_wb("add", 3'd2, 16'h0001);
        issue(4'd2, 3'd2, 3'd3, 8'h00);
        step();
        check_wb("sub_fwd", 3'd2, 16'hFFFF);
        IN_VALID = 1'b0;
        step();
        check("sub.pulse", 32'(REG_WEN), 32'd0);

        // MOV / AND / OR with idle gaps (no forwarding in play)
        REG_2 = 16'hF0F0; REG_3 = 16'h0FF3;
        issue(4'd0, 3'd2, 3'd3, 8'h00); step(); check_wb("mov", 3'd2, 16'h0FF3);
        IN_VALID = 1'b0; step();
        issue(4'd3, 3'd2, 3'd3, 8'h00); step(); check_wb("and", 3'd2, 16'h00F0);
        IN_VALID = 1'b0; step();
        issue(4'd4, 3'd2, 3'd3, 8'h00); step(); check_wb("or", 3'd2, 16'hFFF3);
        IN_VALID = 1'b0; step();

        // shifts of 0x8001 by 4
        REG_4 = 16'h8001; REG_5 = 16'h0004;
        do_shift("sra", 4'd7, 3'd4, 3'd5, 4, 16'hF800);
        do_shift("sr",  4'd6, 3'd4, 3'd5, 4, 16'h0800);
        do_shift("sl",  4'd5, 3'd4, 3'd5, 4, 16'h0010);

        // amount 0: only the low nibble of 0x0010 counts
        REG_6 = 16'h1234; REG_0 = 16'h0010;
        do_shift("sh0", 4'd5, 3'd6, 3'd0, 0, 16'h1234);

        // reset two cycles into an 8-bit shift
        REG_5 = 16'h0008;
        issue(4'd5, 3'd1, 3'd5, 8'h00);
        step();
        IN_VALID = 1'b0;
        step();
        step();
        RESET = 1'b1;
        step();
        check("rst_sh.busy", 32'(BUSY), 32'd0);
        check("rst_sh.data", 32'(REG_IN), 32'd0);
        check("rst_sh.nreg", 32'(N_REG), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("rst_sh.wen", 32'(REG_WEN), 32'd0);
            step();
        end
        RESET = 1'b0;
        step();
        check("rst_sh.rdy", 32'(IN_READY), 32'd1);
        check("rst_sh.wen_after", 32'(REG_WEN), 32'd0);
        check("rst_sh.busy_after", 32'(BUSY), 32'd0);

        // reset coinciding with an accept drops the instruction
        RESET = 1'b1;
        issue(4'd8, 3'd3, 3'd0, 8'h77);
        step();
        check("rst_acc.wen", 32'(REG_WEN), 32'd0);
        check("rst_acc.data", 32'(REG_IN), 32'd0);
        RESET = 1'b0; IN_VALID = 1'b0;
        step();
        check("rst_acc.wen2", 32'(REG_WEN), 32'd0);

        // LDL then LDH on R7: the low byte must come from the forwarded value
        issue(4'd8, 3'd7, 3'd0, 8'hC3);
        step();
        check_wb("ldl7", 3'd7, 16'h00C3);
        issue(4'd9, 3'd7, 3'd0, 8'h3C);
        step();
        check_wb("ldh7", 3'd7, 16'h3CC3);

        // undefined opcode is a NOP and leaves the stage ready
        issue(4'hF, 3'd5, 3'd1, 8'hFF);
        step();
        check("nop.wen", 32'(REG_WEN), 32'd0);
        check("nop.busy", 32'(BUSY), 32'd0);
        check("nop.rdy", 32'(IN_READY), 32'd1);
        IN_VALID = 1'b0;
        step();
        check("nop.wen2", 32'(REG_WEN), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the cpu15 pipeline, directly upstream of the write-back register file.
- Accepts a decoded instruction, selects operands from the eight register-file outputs, computes a 16-bit result, and drives the write-back port (N_REG, REG_IN, REG_WEN) one registered cycle later.
- Shifts are iterative, one bit per cycle. A valid/ready handshake stalls decode during a shift.
- Forwards the pending write-back value to remove read-after-write hazards.

Parameters:
- DW, 16, datapath/register width (only 16 supported).
- SHW, 4, shift-amount width (amount = Rs[SHW-1:0]).

Ports:
- CLK_EX  in  1  stage clock; same net as the write-back clock.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  decoded instruction present.
- IN_READY  out  1  stage can accept; combinational = (state==IDLE) && !RESET.
- OP  in  4  opcode.
- N_RD  in  3  destination / first-operand register index.
- N_RS  in  3  second-operand register index.
- IMM  in  8  immediate.
- REG_0..REG_7  in  16 each  register-file outputs.
- N_REG  out  3  write-back register index.
- REG_IN  out  16  write-back data.
- REG_WEN  out  1  write-back enable, one-cycle pulse per result.
- BUSY  out  1  high while in SHIFT.

Behaviour:
- Clocking and reset: one clock, CLK_EX. RESET is synchronous and active-high.
- Reset values: REG_IN=16'h0000, N_REG=3'b000, REG_WEN=0, BUSY=0, state=IDLE, shift count=0, accumulator=0.
- Accept: a rising edge with IN_VALID && IN_READY.
- Operand fetch:
  - A = REG_[N_RD], B = REG_[N_RS].
  - Forwarding: if REG_WEN==1 and N_REG==index, use REG_IN instead of the register output. Applies to A and B independently.
- Single-cycle ops, all 16-bit with wrap and no flags:
  - 0 MOV: Rd<=B
  - 1 ADD: A+B mod 2^16
  - 2 SUB: A-B mod 2^16
  - 3 AND
  - 4 OR
  - 8 LDL: {8'h00,IMM}
  - 9 LDH: {IMM,A[7:0]}
- Single-cycle timing:
  - On the accept edge, REG_IN<=result, N_REG<=N_RD, REG_WEN<=1.
  - Stay in IDLE, so back-to-back accepts are allowed (one result per cycle).
- Shift ops: 5 SL (logical left), 6 SR (logical right), 7 SRA (arithmetic right).
  - Accept edge: acc<=A, cnt<=B[3:0], latch op and N_RD, state<=SHIFT, BUSY<=1, REG_WEN<=0.
  - SHIFT, cnt!=0: shift acc one bit (SRA replicates bit 15), cnt<=cnt-1.
  - SHIFT, cnt==0: REG_IN<=acc, N_REG<=latched N_RD, REG_WEN<=1, BUSY<=0, state<=IDLE.
  - REG_WEN rises amount+1 edges after the accept edge. Amount 0 gives an unchanged value after 1 extra edge.
- Other opcodes (A..F): accepted as NOP; REG_WEN<=0, no state change.
- REG_WEN is cleared on any edge that does not produce a result. It is never high for two cycles from a single instruction.
- IN_READY is low throughout SHIFT. IN_VALID is ignored there, and upstream must hold the instruction.
- Reset mid-shift: abort, no write issued, return to IDLE next cycle.
- Reset coinciding with an accept: the reset wins and the instruction is dropped.

Test Plan:
- Reset then LDL R1,IMM=8'hA5 -> next cycle REG_WEN=1, N_REG=1, REG_IN=16'h00A5. The following cycle (IN_VALID low) REG_WEN=0.
- R2=16'hFFFF, R3=16'h0002, back-to-back ADD R2,R3 then SUB R2,R3 -> REG_IN=16'h0001 (wrap), then forwarded 16'h0001-2=16'hFFFF. One write per cycle.
- R4=16'h8001, R5=4; SRA R4,R5 -> IN_READY low for 5 cycles, BUSY high, then REG_WEN=1, REG_IN=16'hF800. SR gives 16'h0800, SL gives 16'h0010.
- Shift with amount 0 on R6=16'h1234 -> REG_WEN after 2 edges, REG_IN=16'h1234. IN_VALID held during SHIFT is not consumed twice.
- RESET asserted 2 cycles into an 8-bit shift -> REG_WEN never rises, all outputs zero, IN_READY high the cycle after RESET drops.
- LDH R7,IMM=8'h3C immediately after LDL R7,IMM=8'hC3 -> forwarded result 16'h3CC3. Opcode 4'hF -> no REG_WEN.
